multi_cycle_control: RTL and testbench

- Control unit of the multi-cycle MIPS-subset CPU.
- Sequences each instruction through IF/ID/EXE/MEM/WB from the decoded opCode and the ALU flags.
- Drives every enable and mux select consumed by the datapath: PC, IR, register file, ALU, data memory.
- Exports the current state for the top-level debug/sim ports (PCWre, state).

---
 rtl/multi_cycle_control.sv | 248 ++++++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: state sequencer and control decoder for the multi-cycle
// MIPS-subset CPU. The state and the halt/illegal flags are registered; every
// datapath enable and select is a combinational decode of the current state
// and the opcode/ALU flags.
// Optional build macro: ILLEGAL_TRAP_EN. When it is defined, an unknown opcode
// seen in ID traps (illegal=1, halted=1). Otherwise it executes as add.
module multi_cycle_control #(
    parameter int STATE_W = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [5:0]         opCode,
    input  logic               zero,
    input  logic               sign,
    output logic               PCWre,
    output logic               IRWre,
    output logic               InsMemRW,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic               ExtSel,
    output logic               mRD,
    output logic               mWR,
    output logic               DBDataSrc,
    output logic               RegWre,
    output logic               WrRegDSrc,
    output logic [1:0]         RegDst,
    output logic [1:0]         PCSrc,
    output logic [STATE_W-1:0] state,
    output logic               halted,
    output logic               illegal
);

    typedef enum logic [STATE_W-1:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SLT   = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t     cur_state;
    logic [5:0] op_eff;

    function automatic logic op_known(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLL, OP_SLTI, OP_SLT, OP_SW, OP_LW, OP_BEQ, OP_BNE,
            OP_BLTZ, OP_J, OP_JR, OP_JAL, OP_HALT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic is_rtype(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_SLL) || (op == OP_SLT);
    endfunction

    function automatic logic is_imm_alu(input logic [5:0] op);
        return (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_XORI) || (op == OP_SLTI);
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
    endfunction

    function automatic logic is_jump(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        case (op)
            OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: return 3'b001;
            OP_SLL:                          return 3'b010;
            OP_ORI:                          return 3'b011;
            OP_AND, OP_ANDI:                 return 3'b100;
            OP_XORI:                         return 3'b111;
            OP_SLT, OP_SLTI:                 return 3'b110;
            default:                         return 3'b000;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [5:0] op, input logic z,
                                          input logic s);
        case (op)
            OP_BEQ:  return z;
            OP_BNE:  return !z;
            OP_BLTZ: return s;
            default: return 1'b0;
        endcase
    endfunction

`ifdef ILLEGAL_TRAP_EN
    logic trap;
    logic illegal_q;

    // Unknown opcodes are kept as-is so they decode to no writes at all.
    assign trap   = !op_known(opCode);
    assign op_eff = opCode;

    // Sticky illegal-opcode flag, set when a trap is taken in ID.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            illegal_q <= 1'b0;
        end else if (cur_state == S_ID && trap) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    // Unknown opcodes take the add path.
    assign op_eff  = op_known(opCode) ? opCode : OP_ADD;
    assign illegal = 1'b0;
`endif

    assign state = cur_state;

    // Instruction sequencer and sticky halt flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cur_state <= S_IF;
            halted    <= 1'b0;
        end else begin
            case (cur_state)
                S_IF: begin
                    if (!halted) begin
                        cur_state <= S_ID;
                    end
                end
                S_ID: begin
`ifdef ILLEGAL_TRAP_EN
                    if (trap) begin
                        cur_state <= S_IF;
                        halted    <= 1'b1;
                    end else
`endif
                    if (is_jump(op_eff)) begin
                        cur_state <= S_IF;
                    end else if (op_eff == OP_HALT) begin
                        cur_state <= S_IF;
                        halted    <= 1'b1;
                    end else if (is_branch(op_eff)) begin
                        cur_state <= S_EXE_BR;
                    end else if (op_eff == OP_SW || op_eff == OP_LW) begin
                        cur_state <= S_EXE_LS;
                    end else begin
                        cur_state <= S_EXE_AL;
                    end
                end
                S_EXE_AL: cur_state <= S_WB_AL;
                S_WB_AL:  cur_state <= S_IF;
                S_EXE_BR: cur_state <= S_IF;
                S_EXE_LS: cur_state <= S_MEM;
                S_MEM: begin
                    if (op_eff == OP_LW) begin
                        cur_state <= S_WB_LD;
                    end else begin
                        cur_state <= S_IF;
                    end
                end
                S_WB_LD:  cur_state <= S_IF;
                default:  cur_state <= S_IF;
            endcase
        end
    end

    // Control decode; while reset is asserted every enable and select is held
    // at its idle value so an abandoned instruction cannot write anything.
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b1;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        ExtSel    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        RegWre    = 1'b0;
        WrRegDSrc = 1'b0;
        RegDst    = 2'b00;
        PCSrc     = 2'b00;
        if (RST) begin
            ALUSrcA   = (op_eff == OP_SLL);
            ALUSrcB   = is_imm_alu(op_eff) || (op_eff == OP_SW) || (op_eff == OP_LW);
            ALUOp     = alu_op_of(op_eff);
            ExtSel    = !((op_eff == OP_ANDI) || (op_eff == OP_ORI) || (op_eff == OP_XORI));
            DBDataSrc = (op_eff == OP_LW);
            WrRegDSrc = (op_eff != OP_JAL);
            if (is_rtype(op_eff)) begin
                RegDst = 2'b10;
            end else if (is_imm_alu(op_eff) || op_eff == OP_LW) begin
                RegDst = 2'b01;
            end
            case (cur_state)
                S_IF: IRWre = !halted;
                S_ID: begin
                    if (is_jump(op_eff)) begin
                        PCWre  = 1'b1;
                        PCSrc  = (op_eff == OP_JR) ? 2'b10 : 2'b11;
                        RegWre = (op_eff == OP_JAL);
                    end
                end
                S_EXE_BR: begin
                    PCWre = 1'b1;
                    PCSrc = branch_taken(op_eff, zero, sign) ? 2'b01 : 2'b00;
                end
                S_MEM: begin
                    mRD   = (op_eff == OP_LW);
                    mWR   = (op_eff == OP_SW);
                    PCWre = (op_eff == OP_SW);
                end
                S_WB_AL, S_WB_LD: begin
                    PCWre  = 1'b1;
                    RegWre = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: directed scenarios plus random instruction
// streams, checked against an instruction-level model (phase count per class,
// one PC write in the final phase, writes only where the instruction needs them).
module tb_multi_cycle_control;

    localparam int C_R    = 0;
    localparam int C_I    = 1;
    localparam int C_LW   = 2;
    localparam int C_SW   = 3;
    localparam int C_BR   = 4;
    localparam int C_J    = 5;
    localparam int C_JR   = 6;
    localparam int C_JAL  = 7;
    localparam int C_HALT = 8;
    localparam int C_TRAP = 9;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [5:0] opCode = 6'd0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel;
    logic       mRD, mWR, DBDataSrc, RegWre, WrRegDSrc, halted, illegal;
    logic [2:0] ALUOp;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] state;

    int   compared = 0;
    int   mismatched = 0;
    logic model_halted = 1'b0;
    logic model_illegal = 1'b0;

    logic [5:0] known_ops [18] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000,
                                   6'b010001, 6'b010010, 6'b010011, 6'b011000,
                                   6'b100110, 6'b100111, 6'b110000, 6'b110001,
                                   6'b110100, 6'b110101, 6'b110110, 6'b111000,
                                   6'b111001, 6'b111010};

    always #5 CLK = ~CLK;

    multi_cycle_control #(.STATE_W(3)) dut (
        .CLK(CLK), .RST(RST), .opCode(opCode), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .mRD(mRD), .mWR(mWR),
        .DBDataSrc(DBDataSrc), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc),
        .RegDst(RegDst), .PCSrc(PCSrc), .state(state), .halted(halted),
        .illegal(illegal)
    );

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int class_of(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b010000, 6'b011000, 6'b100111: return C_R;
            6'b000010, 6'b010001, 6'b010010, 6'b010011, 6'b100110: return C_I;
            6'b110001: return C_LW;
            6'b110000: return C_SW;
            6'b110100, 6'b110101, 6'b110110: return C_BR;
            6'b111000: return C_J;
            6'b111001: return C_JR;
            6'b111010: return C_JAL;
            6'b111111: return C_HALT;
`ifdef ILLEGAL_TRAP_EN
            default: return C_TRAP;
`else
            default: return C_R;
`endif
        endcase
    endfunction

    // Cycles taken by each instruction class, IF included.
    function automatic int n_phases(input int c);
        case (c)
            C_R, C_I, C_SW: return 4;
            C_LW:           return 5;
            C_BR:           return 3;
            default:        return 2;
        endcase
    endfunction

    // State visited in phase p of an instruction of class c.
    function automatic logic [2:0] phase_state(input int c, input int p);
        case (p)
            0: return 3'b000;
            1: return 3'b001;
            2: return (c == C_R || c == C_I) ? 3'b110 : (c == C_BR) ? 3'b101 : 3'b010;
            3: return (c == C_R || c == C_I) ? 3'b111 : 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    // {ALUOp, ALUSrcA, ALUSrcB, ExtSel} from the opcode table.
    function automatic logic [5:0] alu_ctrl(input logic [5:0] op);
        case (op)
            6'b000001:                       return {3'b001, 1'b0, 1'b0, 1'b1};
            6'b000010:                       return {3'b000, 1'b0, 1'b1, 1'b1};
            6'b010000:                       return {3'b100, 1'b0, 1'b0, 1'b1};
            6'b010001:                       return {3'b100, 1'b0, 1'b1, 1'b0};
            6'b010010:                       return {3'b011, 1'b0, 1'b1, 1'b0};
            6'b010011:                       return {3'b111, 1'b0, 1'b1, 1'b0};
            6'b011000:                       return {3'b010, 1'b1, 1'b0, 1'b1};
            6'b100110:                       return {3'b110, 1'b0, 1'b1, 1'b1};
            6'b100111:                       return {3'b110, 1'b0, 1'b0, 1'b1};
            6'b110000, 6'b110001:            return {3'b000, 1'b0, 1'b1, 1'b1};
            6'b110100, 6'b110101, 6'b110110: return {3'b001, 1'b0, 1'b0, 1'b1};
            default:                         return {3'b000, 1'b0, 1'b0, 1'b1};
        endcase
    endfunction

    // Run one instruction from IF to its last phase, checking every cycle.
    task automatic run_instr(input logic [5:0] op, input logic z, input logic s);
        int   c;
        int   n;
        logic last;
        logic wr;
        logic taken;
        c = class_of(op);
        n = n_phases(c);
        opCode = op;
        zero = z;
        sign = s;
        for (int p = 0; p < n; p++) begin
            last = (p == n - 1);
            wr = last && (c == C_R || c == C_I || c == C_LW || c == C_JAL);
            @(negedge CLK);
            check("state", 8'(state), 8'(phase_state(c, p)));
            check("IRWre", 8'(IRWre), 8'(p == 0 && !model_halted));
            check("InsMemRW", 8'(InsMemRW), 8'd1);
            check("PCWre", 8'(PCWre), 8'(last && c != C_HALT && c != C_TRAP));
            check("RegWre", 8'(RegWre), 8'(wr));
            check("mRD", 8'(mRD), 8'(p == 3 && c == C_LW));
            check("mWR", 8'(mWR), 8'(p == 3 && c == C_SW));
            check("halted", 8'(halted), 8'(model_halted));
            check("illegal", 8'(illegal), 8'(model_illegal));
            if (p == 2 && c <= C_BR)
                check("alu_ctrl", 8'({ALUOp, ALUSrcA, ALUSrcB, ExtSel}), 8'(alu_ctrl(op)));
            if (last && c == C_BR) begin
                taken = (op == 6'b110100) ? z : (op == 6'b110101) ? !z : s;
                check("PCSrc_br", 8'(PCSrc), taken ? 8'd1 : 8'd0);
            end
            if (last && (c == C_J || c == C_JR || c == C_JAL))
                check("PCSrc_jmp", 8'(PCSrc), (c == C_JR) ? 8'd2 : 8'd3);
            if (wr) begin
                check("RegDst", 8'(RegDst), (c == C_R) ? 8'd2 : (c == C_JAL) ? 8'd0 : 8'd1);
                check("DBDataSrc", 8'(DBDataSrc), 8'(c == C_LW));
                check("WrRegDSrc", 8'(WrRegDSrc), 8'(c != C_JAL));
            end
            @(posedge CLK);
            #1;
        end
        if (c == C_HALT || c == C_TRAP) model_halted = 1'b1;
        if (c == C_TRAP) model_illegal = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 8'(state), 8'd0);
        check({tag, "_flags"}, 8'({halted, illegal}), 8'd0);
        check({tag, "_wen"}, 8'({PCWre, IRWre, RegWre, mWR, mRD}), 8'd0);
        check({tag, "_InsMemRW"}, 8'(InsMemRW), 8'd1);
        check({tag, "_sel"}, 8'({ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc}), 8'd0);
        check({tag, "_sel2"}, 8'({ALUOp, RegDst, PCSrc}), 8'd0);
    endtask

    task automatic hold_halted(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            opCode = 6'($urandom_range(0, 63));
            @(negedge CLK);
            check("halt_state", 8'(state), 8'd0);
            check("halt_wen", 8'({PCWre, IRWre}), 8'd0);
            check("halt_flag", 8'(halted), 8'd1);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Power-on reset, then the directed instructions.
        opCode = 6'b000000;
        repeat (10) @(posedge CLK);
        #1;
        check_idle("reset");
        RST = 1'b1;
        run_instr(6'b000000, 1'b0, 1'b0);
        run_instr(6'b110001, 1'b0, 1'b0);
        run_instr(6'b110100, 1'b1, 1'b0);
        run_instr(6'b110100, 1'b0, 1'b0);
        run_instr(6'b110101, 1'b0, 1'b0);
        run_instr(6'b110110, 1'b0, 1'b1);
        run_instr(6'b111010, 1'b0, 1'b0);
        run_instr(6'b011000, 1'b0, 1'b0);
        run_instr(6'b010010, 1'b0, 1'b0);

        // Reset dropped while a store sits in MEM.
        opCode = 6'b110000;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("sw_mem_state", 8'(state), 8'd3);
        check("sw_mem_mWR", 8'(mWR), 8'd1);
        #2 RST = 1'b0;
        #1;
        check_idle("midreset");
        @(posedge CLK);
        #1 RST = 1'b1;

        // Random instruction stream.
        for (int i = 0; i < 150; i++)
            run_instr(known_ops[$urandom_range(0, 17)], 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));

        // Halt, stay halted, then clear it with a reset pulse.
        run_instr(6'b111111, 1'b0, 1'b0);
        hold_halted(20);
        RST = 1'b0;
        #3;
        check_idle("halt_clear");
        @(posedge CLK);
        #1 RST = 1'b1;
        model_halted = 1'b0;
        run_instr(6'b000001, 1'b0, 1'b0);

        // Opcode outside the table.
        run_instr(6'b101010, 1'b0, 1'b0);
        if (model_halted) hold_halted(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
